// File: rtl/spi_adapter_pkg.sv
// rtl/spi_adapter_pkg.sv - shared widths and packet helpers for the multi-channel SPI minion adapter
package spi_adapter_pkg;

  // Packets are handled through a fixed-width carrier so the helpers work for any dbits/cbits.
  localparam int unsigned pkt_max_bits = 64;

  // All-zero word driven on pull_msg_data whenever nothing is being pulled.
  localparam logic [pkt_max_bits-1:0] pull_idle_word = '0;

  // Address width for n slots, never narrower than one bit.
  function automatic int calc_cbits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Channel-address field: everything above the payload bits.
  function automatic logic [pkt_max_bits-1:0] pkt_chan(input logic [pkt_max_bits-1:0] pkt,
                                                       input int dbits);
    return pkt >> dbits;
  endfunction

  // Payload field: the low dbits of the packet.
  function automatic logic [pkt_max_bits-1:0] pkt_data(input logic [pkt_max_bits-1:0] pkt,
                                                       input int dbits);
    return pkt & ((64'd1 << dbits) - 64'd1);
  endfunction

endpackage

// File: rtl/spi_adapter_fifo.sv
// rtl/spi_adapter_fifo.sv - per-channel registered FIFO with full/empty/free-count status
module spi_adapter_fifo
  import spi_adapter_pkg::*;
#(
  parameter int dbits = 8,
  parameter int depth = 2,
  localparam int fbits = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq,
  input  logic [dbits-1:0] enq_data,
  input  logic             deq,
  output logic [dbits-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [fbits-1:0] num_free
);

  localparam int abits = calc_cbits(depth);
  localparam logic [abits-1:0] last_slot = abits'(depth - 1);
  localparam logic [fbits-1:0] depth_cnt = fbits'(depth);

  logic [dbits-1:0] mem [depth];
  logic [abits-1:0] wr_ptr;
  logic [abits-1:0] rd_ptr;
  logic [fbits-1:0] count;
  logic             do_enq;
  logic             do_deq;

  assign full     = (count == depth_cnt);
  assign empty    = (count == '0);
  assign num_free = depth_cnt - count;
  assign do_enq   = enq & ~full;
  assign do_deq   = deq & ~empty;
  assign head     = mem[rd_ptr];

  // Storage, pointers and occupancy; a reset wipes every entry so no stale data survives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < depth; i++) mem[i] <= '0;
    end else begin
      if (do_enq) begin
        mem[wr_ptr] <= enq_data;
        wr_ptr      <= (wr_ptr == last_slot) ? '0 : wr_ptr + 1'b1;
      end
      if (do_deq) begin
        rd_ptr <= (rd_ptr == last_slot) ? '0 : rd_ptr + 1'b1;
      end
      if (do_enq && !do_deq) begin
        count <= count + 1'b1;
      end else if (do_deq && !do_enq) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_minion_adapter_multichan.sv
// rtl/spi_minion_adapter_multichan.sv - SPI minion push/pull to nchan val/rdy channel pairs
module spi_minion_adapter_multichan
  import spi_adapter_pkg::*;
#(
  parameter int dbits = 8,
  parameter int nchan = 4,
  parameter int depth = 2,
  localparam int cbits = calc_cbits(nchan)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pull_en,
  output logic                   pull_msg_val,
  output logic                   pull_msg_spc,
  output logic [cbits+dbits-1:0] pull_msg_data,
  input  logic                   push_en,
  input  logic                   push_msg_val_wrt,
  input  logic                   push_msg_val_rd,
  input  logic [cbits+dbits-1:0] push_msg_data,
  input  logic [nchan*dbits-1:0] recv_msg,
  input  logic [nchan-1:0]       recv_val,
  output logic [nchan-1:0]       recv_rdy,
  output logic [nchan*dbits-1:0] send_msg,
  output logic [nchan-1:0]       send_val,
  input  logic [nchan-1:0]       send_rdy,
  output logic [nchan-1:0]       parity,
  input  logic                   err_clr,
  output logic [nchan-1:0]       err_overflow,
  output logic                   err_underflow
);

  localparam int fbits = $clog2(depth + 1);

  logic             wr;
  logic             rd;
  logic [cbits-1:0] addr;
  logic [dbits-1:0] wdata;
  logic [nchan-1:0] hit;
  logic [nchan-1:0] ovf_set;

  logic [nchan-1:0] mc_full;
  logic [nchan-1:0] mc_empty;
  logic [nchan-1:0] mc_enq;
  logic [nchan-1:0] mc_deq;
  logic [fbits-1:0] mc_free [nchan];
  logic [dbits-1:0] mc_head [nchan];

  logic [nchan-1:0] cm_full;
  logic [nchan-1:0] cm_empty;
  logic [nchan-1:0] cm_enq;
  logic [nchan-1:0] cm_deq;
  logic [fbits-1:0] cm_free_unused [nchan];
  logic [dbits-1:0] cm_head [nchan];

  logic [cbits-1:0] rr_ptr;
  logic [cbits-1:0] grant_id;
  logic [cbits-1:0] scan_id;
  logic             grant_found;
  logic             rdy_en;

  assign wr    = push_en & push_msg_val_wrt;
  assign rd    = pull_en & push_msg_val_rd;
  assign addr  = cbits'(pkt_chan(pkt_max_bits'(push_msg_data), dbits));
  assign wdata = dbits'(pkt_data(pkt_max_bits'(push_msg_data), dbits));

  for (genvar c = 0; c < nchan; c++) begin : g_chan
    // Out-of-range addresses match no channel, so they are dropped without a flag.
    assign hit[c]     = wr && (addr == cbits'(c));
    assign ovf_set[c] = hit[c] & mc_full[c];
    assign mc_enq[c]  = hit[c] & ~mc_full[c];
    assign send_val[c] = ~mc_empty[c];
    assign mc_deq[c]  = send_val[c] & send_rdy[c];
    assign send_msg[c*dbits +: dbits] = mc_head[c];
    assign parity[c]  = (^mc_head[c]) & send_val[c];

    assign recv_rdy[c] = rdy_en & ~cm_full[c];
    assign cm_enq[c]   = recv_val[c] & recv_rdy[c];
    assign cm_deq[c]   = pull_msg_val && (grant_id == cbits'(c));

    spi_adapter_fifo #(.dbits(dbits), .depth(depth)) u_mc_fifo (
      .clk      (clk),
      .reset    (reset),
      .enq      (mc_enq[c]),
      .enq_data (wdata),
      .deq      (mc_deq[c]),
      .head     (mc_head[c]),
      .full     (mc_full[c]),
      .empty    (mc_empty[c]),
      .num_free (mc_free[c])
    );

    spi_adapter_fifo #(.dbits(dbits), .depth(depth)) u_cm_fifo (
      .clk      (clk),
      .reset    (reset),
      .enq      (cm_enq[c]),
      .enq_data (recv_msg[c*dbits +: dbits]),
      .deq      (cm_deq[c]),
      .head     (cm_head[c]),
      .full     (cm_full[c]),
      .empty    (cm_empty[c]),
      .num_free (cm_free_unused[c])
    );
  end

  // Space is reported only if every channel still has a slot after this cycle's write lands.
  always_comb begin
    pull_msg_spc = 1'b1;
    for (int c = 0; c < nchan; c++) begin
      if (hit[c] ? (mc_free[c] <= fbits'(1)) : (mc_free[c] == '0)) begin
        pull_msg_spc = 1'b0;
      end
    end
  end

  // Round-robin scan: first non-empty core->minion queue at or after rr_ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_id     = '0;
    for (int i = 0; i < nchan; i++) begin
      scan_id = cbits'((int'(rr_ptr) + i) % nchan);
      if (!grant_found && !cm_empty[scan_id]) begin
        grant_found = 1'b1;
        grant_id    = scan_id;
      end
    end
  end

  assign pull_msg_val  = rd & grant_found;
  assign pull_msg_data = pull_msg_val ? {grant_id, cm_head[grant_id]}
                                      : (cbits+dbits)'(pull_idle_word);

  // Advance the arbiter past each granted channel; recv_rdy comes up one edge after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (pull_msg_val) begin
        rr_ptr <= (grant_id == cbits'(nchan - 1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

  // Sticky error flags: clear on err_clr, but a new error in the same cycle wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_overflow  <= '0;
      err_underflow <= 1'b0;
    end else begin
      err_overflow  <= (err_clr ? '0 : err_overflow) | ovf_set;
      err_underflow <= (err_clr ? 1'b0 : err_underflow) | (rd & ~grant_found);
    end
  end

endmodule

// File: tb/tb_spi_minion_adapter_multichan.sv
// tb/tb_spi_minion_adapter_multichan.sv - self-checking bench with queue-level reference model
module tb_spi_minion_adapter_multichan;

  localparam int DB = 8;
  localparam int NC = 4;
  localparam int DP = 2;
  localparam int CB = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          pull_en;
  logic          pull_msg_val;
  logic          pull_msg_spc;
  logic [CB+DB-1:0] pull_msg_data;
  logic          push_en;
  logic          push_msg_val_wrt;
  logic          push_msg_val_rd;
  logic [CB+DB-1:0] push_msg_data;
  logic [NC*DB-1:0] recv_msg;
  logic [NC-1:0] recv_val;
  logic [NC-1:0] recv_rdy;
  logic [NC*DB-1:0] send_msg;
  logic [NC-1:0] send_val;
  logic [NC-1:0] send_rdy;
  logic [NC-1:0] parity;
  logic          err_clr;
  logic [NC-1:0] err_overflow;
  logic          err_underflow;

  always #5 clk = ~clk;

  spi_minion_adapter_multichan #(.dbits(DB), .nchan(NC), .depth(DP)) dut (
    .clk              (clk),
    .reset            (reset),
    .pull_en          (pull_en),
    .pull_msg_val     (pull_msg_val),
    .pull_msg_spc     (pull_msg_spc),
    .pull_msg_data    (pull_msg_data),
    .push_en          (push_en),
    .push_msg_val_wrt (push_msg_val_wrt),
    .push_msg_val_rd  (push_msg_val_rd),
    .push_msg_data    (push_msg_data),
    .recv_msg         (recv_msg),
    .recv_val         (recv_val),
    .recv_rdy         (recv_rdy),
    .send_msg         (send_msg),
    .send_val         (send_val),
    .send_rdy         (send_rdy),
    .parity           (parity),
    .err_clr          (err_clr),
    .err_overflow     (err_overflow),
    .err_underflow    (err_underflow)
  );

  int checks = 0;
  int fails  = 0;

  // Reference model: plain queues per channel plus arbiter pointer and flags.
  logic [7:0]    mc_q [NC][$];
  logic [7:0]    cm_q [NC][$];
  int            rr;
  logic [NC-1:0] m_ovf;
  logic          m_und;
  logic          m_rdy_en;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    pull_en = 0; push_en = 0; push_msg_val_wrt = 0; push_msg_val_rd = 0;
    push_msg_data = '0; recv_msg = '0; recv_val = '0; send_rdy = '0; err_clr = 0;
  endtask

  task automatic model_clear();
    for (int c = 0; c < NC; c++) begin
      mc_q[c].delete();
      cm_q[c].delete();
    end
    rr = 0; m_ovf = '0; m_und = 0; m_rdy_en = 0;
  endtask

  task automatic wr_pkt(input int ch, input logic [7:0] d);
    push_en = 1; push_msg_val_wrt = 1; push_msg_data = {2'(ch), d};
  endtask

  // Called just after a falling edge with inputs set: check all outputs, then advance the model at the rising edge.
  task automatic cycle();
    logic wr, rd, e_spc, e_pv, full_pre;
    int addr, g;
    logic [NC-1:0] e_sv, e_rr, e_par, hit, ovf_set;
    logic [31:0] e_msg, mask;
    logic [9:0] e_pd;
    #1;
    wr = push_en & push_msg_val_wrt;
    rd = pull_en & push_msg_val_rd;
    addr = int'(push_msg_data[9:8]);
    e_spc = 1; g = -1; e_msg = '0; mask = '0; e_par = '0;
    for (int c = 0; c < NC; c++) begin
      hit[c]  = wr && (addr == c);
      e_sv[c] = mc_q[c].size() > 0;
      if (e_sv[c]) begin
        mask[c*8 +: 8]  = 8'hff;
        e_msg[c*8 +: 8] = mc_q[c][0];
        e_par[c]        = ^mc_q[c][0];
      end
      e_rr[c] = m_rdy_en && (cm_q[c].size() < DP);
      if (mc_q[c].size() + (hit[c] ? 1 : 0) > DP - 1) e_spc = 0;
    end
    for (int i = 0; i < NC; i++) begin
      if (g < 0 && cm_q[(rr + i) % NC].size() > 0) g = (rr + i) % NC;
    end
    e_pv = rd && (g >= 0);
    e_pd = '0;
    if (e_pv) e_pd = {2'(g), cm_q[g][0]};

    check("send_val", 64'(send_val), 64'(e_sv));
    check("send_msg", 64'(send_msg & mask), 64'(e_msg));
    check("parity", 64'(parity), 64'(e_par));
    check("recv_rdy", 64'(recv_rdy), 64'(e_rr));
    check("err_overflow", 64'(err_overflow), 64'(m_ovf));
    check("err_underflow", 64'(err_underflow), 64'(m_und));
    check("pull_msg_spc", 64'(pull_msg_spc), 64'(e_spc));
    check("pull_msg_val", 64'(pull_msg_val), 64'(e_pv));
    check("pull_msg_data", 64'(pull_msg_data), 64'(e_pd));

    @(posedge clk);
    ovf_set = '0;
    for (int c = 0; c < NC; c++) begin
      full_pre = (mc_q[c].size() == DP);
      if (send_rdy[c] && e_sv[c]) void'(mc_q[c].pop_front());
      if (hit[c]) begin
        if (full_pre) ovf_set[c] = 1;
        else mc_q[c].push_back(push_msg_data[7:0]);
      end
      if (e_pv && g == c) void'(cm_q[c].pop_front());
      if (recv_val[c] && e_rr[c]) cm_q[c].push_back(recv_msg[c*8 +: 8]);
    end
    if (e_pv) rr = (g + 1) % NC;
    m_ovf = (err_clr ? '0 : m_ovf) | ovf_set;
    m_und = (err_clr ? 1'b0 : m_und) | (rd && g < 0);
    m_rdy_en = 1;
    @(negedge clk);
  endtask

  // Drop reset between edges, check the immediate effect, release on the next falling edge.
  task automatic async_reset();
    idle();
    @(posedge clk);
    #2;
    reset = 0;
    #1;
    check("rst_send_val", 64'(send_val), 64'd0);
    check("rst_recv_rdy", 64'(recv_rdy), 64'd0);
    check("rst_parity", 64'(parity), 64'd0);
    check("rst_err", 64'({err_overflow, err_underflow}), 64'd0);
    model_clear();
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    idle();
    model_clear();
    #12;
    check("reset_send_val", 64'(send_val), 64'd0);
    check("reset_pull_val", 64'(pull_msg_val), 64'd0);
    check("reset_pull_data", 64'(pull_msg_data), 64'd0);
    check("reset_recv_rdy", 64'(recv_rdy), 64'd0);
    check("reset_flags", 64'({err_overflow, err_underflow}), 64'd0);
    @(negedge clk);
    reset = 1;
    cycle();

    // Single write to ch2, then drain it.
    wr_pkt(2, 8'hA5);
    cycle();
    idle(); send_rdy = 4'b0100;
    #1;
    check("wr_send_val", 64'(send_val), 64'h4);
    check("wr_send_msg2", 64'(send_msg[23:16]), 64'hA5);
    check("wr_parity", 64'(parity), 64'h0);
    cycle();
    idle();
    #1;
    check("drain_send_val", 64'(send_val), 64'h0);
    cycle();

    // Fill ch1, overflow on the third write, then clear the flag.
    wr_pkt(1, 8'h31); cycle();
    wr_pkt(1, 8'h32);
    #1;
    check("fill_spc", 64'(pull_msg_spc), 64'h0);
    cycle();
    wr_pkt(1, 8'h77); cycle();
    idle();
    #1;
    check("ovf_flag", 64'(err_overflow), 64'h2);
    check("ovf_head", 64'(send_msg[15:8]), 64'h31);
    send_rdy = 4'b0010;
    cycle();
    idle();
    #1;
    check("ovf_second", 64'(send_msg[15:8]), 64'h32);
    err_clr = 1; send_rdy = 4'b0010;
    cycle();
    idle();
    #1;
    check("clr_flag", 64'(err_overflow), 64'h0);
    cycle();

    // Round robin over ch0/ch3.
    recv_val = 4'b1001; recv_msg = {8'h33, 8'h00, 8'h00, 8'h11}; cycle();
    idle(); recv_val = 4'b0001; recv_msg = 32'h22; cycle();
    idle(); pull_en = 1; push_msg_val_rd = 1;
    #1; check("rr_0", 64'(pull_msg_data), 64'h011); cycle();
    #1; check("rr_1", 64'(pull_msg_data), 64'h333); cycle();
    #1; check("rr_2", 64'(pull_msg_data), 64'h022); cycle();

    // Underflow with all queues empty; pointer must stay at 1.
    #1;
    check("und_val", 64'(pull_msg_val), 64'h0);
    check("und_data", 64'(pull_msg_data), 64'h0);
    cycle();
    idle();
    #1; check("und_flag", 64'(err_underflow), 64'h1);
    recv_val = 4'b0110; recv_msg = {8'h00, 8'h52, 8'h51, 8'h00}; cycle();
    idle(); pull_en = 1; push_msg_val_rd = 1;
    #1; check("rr_kept", 64'(pull_msg_data), 64'h151); cycle();
    cycle();
    idle(); err_clr = 1; cycle();

    // Write ch0, read and core-enqueue ch0 in the same cycle.
    idle(); recv_val = 4'b0001; recv_msg = 32'h61; cycle();
    idle(); wr_pkt(0, 8'h99); pull_en = 1; push_msg_val_rd = 1;
    recv_val = 4'b0001; recv_msg = 32'h62;
    cycle();
    idle();
    #1; check("sim_rdy_one", 64'(recv_rdy[0]), 64'h1);
    recv_val = 4'b0001; recv_msg = 32'h63; cycle();
    idle();
    #1; check("sim_rdy_full", 64'(recv_rdy[0]), 64'h0);
    cycle();

    // Two entries on ch2, then reset between edges.
    wr_pkt(2, 8'h0F); cycle();
    wr_pkt(2, 8'hF1); cycle();
    async_reset();
    idle(); cycle(); cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      idle();
      push_en = 1'($urandom);
      push_msg_val_wrt = 1'($urandom);
      pull_en = 1'($urandom);
      push_msg_val_rd = 1'($urandom);
      push_msg_data = 10'($urandom);
      recv_val = 4'($urandom);
      recv_msg = $urandom;
      send_rdy = 4'($urandom);
      err_clr = ($urandom_range(0, 15) == 0);
      cycle();
      if ($urandom_range(0, 63) == 0) async_reset();
    end

    idle();
    cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
